shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised universal shift register; successor to the single-bit async-reset D flip-flop.
- Supports hold, shift right, shift left and parallel load, with serial in/out on both ends.
- A saturating shift counter flags when a full word has been shifted since the last load.
- Used as the serialiser/deserialiser and general storage stage in the lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CW, $clog2(WIDTH+1), counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; 0 = all state holds.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input; enters q[WIDTH-1] on shift right.
- sin_l  input  1  serial input; enters q[0] on shift left.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0] (bit leaving on shift right), combinational from q.
- sout_l  output  1  q[WIDTH-1] (bit leaving on shift left), combinational from q.
- cnt  output  CW  shifts performed since the last load or reset, saturating at WIDTH.
- done  output  1  high when cnt == WIDTH, combinational from cnt.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset).
- Reset (reset=0):
  - Immediately, without a clock edge: q=RESET_VAL, cnt=0, so done=0, sout_r=RESET_VAL[0], sout_l=RESET_VAL[WIDTH-1].
  - Holds while low, whatever en/mode/d are.
- Reset release: first state update occurs on the first rising clk edge with reset=1.
- Reset mid-shift: clears q and cnt at once; the partially shifted word is lost and there is no recovery.
- All updates happen on rising clk and only when en=1. en=0 leaves q and cnt unchanged for any mode.
- mode 00, hold: q and cnt unchanged.
- mode 01, shift right: q <= {sin_r, q[WIDTH-1:1]}. cnt <= cnt+1 if cnt<WIDTH, else it stays at WIDTH.
- mode 10, shift left: q <= {q[WIDTH-2:0], sin_l}. cnt is updated as for shift right.
- mode 11, parallel load: q <= d, cnt <= 0, so done drops the cycle after the load edge.
- Latency: one cycle from the enabled edge to q; sout_r, sout_l and done follow q/cnt with no extra cycle.
- Saturation: with cnt==WIDTH, further shifts keep changing q while cnt stays at WIDTH and done stays 1. There is no wrap to 0.
- Mixed directions: right and left shifts both increment the same counter; cnt does not track direction.
- No X propagation: mode is fully decoded and there is no illegal encoding.

Optional Feature:
- Macro: SHIFT_REG_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit), placed after sin_l.
  - With rot=1, mode 01 gives q <= {q[0], q[WIDTH-1:1]} and mode 10 gives q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin_r and sin_l are ignored.
  - cnt still increments or saturates as for a shift.
  - rot has no effect in modes 00 and 11.
- Not defined: no rot port, and shifts always take sin_r/sin_l as above.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'h00. Drive reset=0 mid-cycle with q=8'hA5 -> q=8'h00 and cnt=0 at once, before any clk edge. Release reset, then load d=8'h3C on the next edge -> q=8'h3C.
- Serialise: load 8'hB4, then 8 shift-right edges with sin_r=0 -> sout_r sequence 0,0,1,0,1,1,0,1. cnt goes 1..8, done=1 after the 8th edge, q=8'h00.
- Deserialise: load 8'h00, then shift left with sin_l bits 1,0,1,0,0,1,1,1 -> q=8'hA7, done=1. A 9th shift with sin_l=0 -> q=8'h4E, cnt stays 8.
- Enable and hold: load 8'h5A, en=0 with mode=01 for 3 edges -> q=8'h5A, cnt=0. en=1 with mode=00 for 2 edges -> still unchanged.
- Reload mid-stream: after 5 shifts (cnt=5), load 8'hFF -> cnt=0, done=0, q=8'hFF.
- Rotate (SHIFT_REG_ROTATE_EN defined): load 8'h81, rot=1, shift right 1 edge -> q=8'hC0. Shift left 2 edges -> q=8'h03, cnt=3.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right/left, parallel load, saturating shift counter.
// Optional macro SHIFT_REG_ROTATE_EN adds a rot input that turns shifts into rotates.
module shift_reg_univ #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0]    MODE_HOLD  = 2'b00;
  localparam logic [1:0]    MODE_SHR   = 2'b01;
  localparam logic [1:0]    MODE_SHL   = 2'b10;
  localparam logic [1:0]    MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] CNT_FULL   = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             fill_r_s;
  logic             fill_l_s;

  // Serial fill bits: external serial inputs, or the opposite end of q when rotating.
  always_comb begin
    fill_r_s = sin_r;
    fill_l_s = sin_l;
`ifdef SHIFT_REG_ROTATE_EN
    if (rot) begin
      fill_r_s = q_r[0];
      fill_l_s = q_r[WIDTH-1];
    end else begin
      fill_r_s = sin_r;
      fill_l_s = sin_l;
    end
`endif
  end

  // Counter saturates at WIDTH; it never wraps.
  always_comb begin
    if (cnt_r < CNT_FULL) begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end else begin
      cnt_inc_s = CNT_FULL;
    end
  end

  // Next-state decode for q and cnt.
  always_comb begin
    q_nxt_s   = q_r;
    cnt_nxt_s = cnt_r;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_nxt_s   = q_r;
          cnt_nxt_s = cnt_r;
        end
        MODE_SHR: begin
          q_nxt_s   = {fill_r_s, q_r[WIDTH-1:1]};
          cnt_nxt_s = cnt_inc_s;
        end
        MODE_SHL: begin
          q_nxt_s   = {q_r[WIDTH-2:0], fill_l_s};
          cnt_nxt_s = cnt_inc_s;
        end
        MODE_LOAD: begin
          q_nxt_s   = d;
          cnt_nxt_s = CNT_ZERO;
        end
        default: begin
          q_nxt_s   = q_r;
          cnt_nxt_s = cnt_r;
        end
      endcase
    end else begin
      q_nxt_s   = q_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= RESET_VAL;
      cnt_r <= CNT_ZERO;
    end else begin
      q_r   <= q_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign q      = q_r;
  assign cnt    = cnt_r;
  assign sout_r = q_r[0];
  assign sout_l = q_r[WIDTH-1];
  assign done   = (cnt_r == CNT_FULL);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Table-driven bench for shift_reg_univ (WIDTH=8); expected rows flow through a scoreboard queue.
module tb_shift_reg_univ;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_r;
  logic       sin_l;
  logic       rot;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] cnt;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sr;
    logic       sl;
    logic       rot;
    logic [7:0] eq;
    logic [3:0] ec;
    logic       ed;
  } vec_t;

  typedef struct {
    logic [7:0] eq;
    logic [3:0] ec;
    logic       ed;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
`ifdef SHIFT_REG_ROTATE_EN
    .rot    (rot),
`endif
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int idx, input logic [7:0] eq, input logic [3:0] ec, input logic ed);
    chk({nm, ".q"}, idx, 32'(q), 32'(eq));
    chk({nm, ".cnt"}, idx, 32'(cnt), 32'(ec));
    chk({nm, ".done"}, idx, 32'(done), 32'(ed));
    chk({nm, ".sout_r"}, idx, 32'(sout_r), 32'(eq[0]));
    chk({nm, ".sout_l"}, idx, 32'(sout_l), 32'(eq[7]));
  endtask

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic [7:0] dd,
                              input logic r, input logic l, input logic ro,
                              input logic [7:0] eq, input logic [3:0] ec, input logic ed);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.sr = r; v.sl = l; v.rot = ro;
    v.eq = eq; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  // Drive one row at negedge, push its expectation, then pop and compare just after the edge.
  task automatic apply(input vec_t v, input string nm, input int idx);
    exp_t e;
    @(negedge clk);
    en = v.en; mode = v.mode; d = v.d; sin_r = v.sr; sin_l = v.sl; rot = v.rot;
    e.eq = v.eq; e.ec = v.ec; e.ed = v.ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d] scoreboard empty got=0 expected=1", nm, idx);
    end else begin
      e = sb.pop_front();
      check_all(nm, idx, e.eq, e.ec, e.ed);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
    #1;
    check_all("reset_init", 0, 8'h00, 4'd0, 1'b0);

    // Reset mid-shift: load A5, shift twice, then pull reset between edges.
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0), "pre_rst", 0);
    apply(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h4A, 4'd1, 1'b0), "pre_rst", 1);
    apply(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h94, 4'd2, 1'b0), "pre_rst", 2);
    #1;
    reset = 1'b0;
    mode  = 2'b11;
    d     = 8'hFF;
    #1;
    check_all("async_rst", 0, 8'h00, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 0, 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd0, 1'b0), "post_rst", 0);

    // Serialise B4 LSB first, then one saturated shift.
    vecs.push_back(mk(1'b1, 2'b11, 8'hB4, 1'b0, 1'b0, 1'b0, 8'hB4, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h2D, 4'd2, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h16, 4'd3, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0B, 4'd4, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 4'd5, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 4'd6, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 4'd7, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd8, 1'b1));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 4'd8, 1'b1));
    // Deserialise 1,0,1,0,0,1,1,1 into A7, then a saturated ninth shift.
    vecs.push_back(mk(1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 4'd1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 4'd2, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 4'd3, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 4'd4, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h14, 4'd5, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h29, 4'd6, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h53, 4'd7, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA7, 4'd8, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h4E, 4'd8, 1'b1));
    // Enable low and hold mode leave everything untouched.
    vecs.push_back(mk(1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h5A, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h5A, 4'd0, 1'b0));
    // Reload mid-stream after 5 shifts, then mixed directions on one counter.
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hAD, 4'd1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hD6, 4'd2, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hEB, 4'd3, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hF5, 4'd4, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFA, 4'd5, 1'b0));
    vecs.push_back(mk(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE, 4'd1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F, 4'd2, 1'b0));
`ifdef SHIFT_REG_ROTATE_EN
    vecs.push_back(mk(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 4'd0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC0, 4'd1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1, 8'h81, 4'd2, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 4'd3, 1'b0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], "vec", i);
    end

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
